multi_button_events: RTL and testbench

MULTI_BUTTON_EVENTS -- requirements
Module: multi_button_events

---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_channel.sv | 139 +++++++++++++
 rtl/multi_button_events.sv | 41 ++++
 tb/tb_multi_button_events.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button-event channels: FSM encoding and
// the helpers that turn millisecond parameters into cycle counts and widths.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2,
        ST_REPEAT  = 2'd3
    } btn_state_e;

    // Divide before multiplying so large CLK_HZ values stay within 32 bits.
    function automatic int cyc_count(input int clk_hz, input int ms);
        int c;
        c = (clk_hz / 1000) * ms;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int cnt_width(input int cyc);
        return $clog2(cyc) + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debouncer and the
// press / long-press / auto-repeat FSM with registered one-cycle pulses.
module btn_channel
    import btn_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_MS       = 1000,
    parameter int REPEAT_MS     = 200,
    parameter int ACTIVE_LOW_IN = 0
) (
    input  logic clk,
    input  logic rst_a_n,
    input  logic btn_in,
    input  logic repeat_en,
    output logic level_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DEB_CYC  = cyc_count(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYC = cyc_count(CLK_HZ, LONG_MS);
    localparam int REP_CYC  = cyc_count(CLK_HZ, REPEAT_MS);
    localparam int DW       = cnt_width(DEB_CYC);
    localparam int HW       = max_int(cnt_width(LONG_CYC), cnt_width(REP_CYC));

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYC - 1);

    logic          btn_int;
    logic          sync1, sync2;
    logic [DW-1:0] deb_cnt;
    logic          deb_hit, press_ev, release_ev;

    btn_state_e    state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          long_nxt, rep_nxt;

    // Inversion sits ahead of the synchronizer so reset holds "released".
    assign btn_int = (ACTIVE_LOW_IN != 0) ? ~btn_in : btn_in;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_int;
            sync2 <= sync1;
        end
    end

    assign deb_hit    = (sync2 != level_out) && (deb_cnt == DEB_LAST);
    assign press_ev   = deb_hit && !level_out;
    assign release_ev = deb_hit && level_out;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            deb_cnt       <= '0;
            level_out     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= press_ev;
            release_pulse <= release_ev;
            if (sync2 == level_out || deb_hit) deb_cnt <= '0;
            else                               deb_cnt <= deb_cnt + 1'b1;
            if (deb_hit) level_out <= ~level_out;
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            long_pulse   <= long_nxt;
            repeat_pulse <= rep_nxt;
        end
    end

    // Release is checked first so it suppresses a coincident long/repeat.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        long_nxt  = 1'b0;
        rep_nxt   = 1'b0;
        if (release_ev) begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press_ev) begin
                        state_nxt = ST_PRESSED;
                        hold_nxt  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (hold_cnt == LONG_LAST) begin
                        long_nxt  = 1'b1;
                        hold_nxt  = '0;
                        state_nxt = repeat_en ? ST_REPEAT : ST_HELD;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!repeat_en) begin
                        state_nxt = ST_HELD;
                        hold_nxt  = '0;
                    end else if (hold_cnt == REP_LAST) begin
                        rep_nxt  = 1'b1;
                        hold_nxt = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (repeat_en) begin
                        state_nxt = ST_REPEAT;
                        hold_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_button_events.sv
// Array of independent button channels; the top only slices ports.
module multi_button_events #(
    parameter int N_CH          = 4,
    parameter int CLK_HZ        = 50000000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_MS       = 1000,
    parameter int REPEAT_MS     = 200,
    parameter int ACTIVE_LOW_IN = 0
) (
    input  logic            clk,
    input  logic            rst_a_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        btn_channel #(
            .CLK_HZ       (CLK_HZ),
            .DEBOUNCE_MS  (DEBOUNCE_MS),
            .LONG_MS      (LONG_MS),
            .REPEAT_MS    (REPEAT_MS),
            .ACTIVE_LOW_IN(ACTIVE_LOW_IN)
        ) u_ch (
            .clk          (clk),
            .rst_a_n      (rst_a_n),
            .btn_in       (btn_in[gi]),
            .repeat_en    (repeat_en[gi]),
            .level_out    (level_out[gi]),
            .press_pulse  (press_pulse[gi]),
            .release_pulse(release_pulse[gi]),
            .long_pulse   (long_pulse[gi]),
            .repeat_pulse (repeat_pulse[gi])
        );
    end

endmodule

// File: tb/tb_multi_button_events.sv
// Bench for multi_button_events: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed cycle expectations.
module tb_multi_button_events;

    localparam int N_CH    = 4;
    localparam int CLK_HZ  = 1000;
    localparam int DEB_MS  = 4;
    localparam int LONG_MS = 20;
    localparam int REP_MS  = 5;
    localparam int DEB     = CLK_HZ / 1000 * DEB_MS;
    localparam int LONG    = CLK_HZ / 1000 * LONG_MS;
    localparam int REP     = CLK_HZ / 1000 * REP_MS;

    localparam int M_IDLE = 0, M_WAIT = 1, M_HOLD = 2, M_RPT = 3;

    logic            clk = 1'b0;
    logic            rst_a_n;
    logic [N_CH-1:0] btn_in, repeat_en;
    logic [N_CH-1:0] level_out, press_pulse, release_pulse, long_pulse, repeat_pulse;

    int errors = 0;
    int checks = 0;
    bit run = 1'b1;

    multi_button_events #(
        .N_CH(N_CH), .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEB_MS),
        .LONG_MS(LONG_MS), .REPEAT_MS(REP_MS), .ACTIVE_LOW_IN(0)
    ) dut (
        .clk(clk), .rst_a_n(rst_a_n), .btn_in(btn_in), .repeat_en(repeat_en),
        .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Input seen by the debouncer is the raw sample from two edges earlier;
    // the level flips once the last DEB such samples all disagree with it.
    int              now = 0;
    bit              d1 [N_CH];
    bit              d2 [N_CH];
    bit              win[N_CH][DEB];
    int              mode[N_CH];
    int              t_press[N_CH];
    int              t_phase[N_CH];
    logic [N_CH-1:0] e_lvl = '0, e_pr = '0, e_rl = '0, e_lg = '0, e_rp = '0;

    always @(posedge clk) begin
        if (!rst_a_n) begin
            e_lvl = '0; e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
            for (int c = 0; c < N_CH; c++) begin
                d1[c] = 1'b0; d2[c] = 1'b0; mode[c] = M_IDLE;
                for (int i = 0; i < DEB; i++) win[c][i] = 1'b0;
            end
        end else begin
            now++;
            for (int c = 0; c < N_CH; c++) begin
                bit s, all_diff;
                s = d2[c]; d2[c] = d1[c]; d1[c] = btn_in[c];
                for (int i = DEB - 1; i > 0; i--) win[c][i] = win[c][i-1];
                win[c][0] = s;
                all_diff = 1'b1;
                for (int i = 0; i < DEB; i++) if (win[c][i] == e_lvl[c]) all_diff = 1'b0;
                e_pr[c] = 1'b0; e_rl[c] = 1'b0; e_lg[c] = 1'b0; e_rp[c] = 1'b0;
                if (all_diff) begin
                    e_lvl[c] = ~e_lvl[c];
                    if (e_lvl[c]) e_pr[c] = 1'b1; else e_rl[c] = 1'b1;
                end
                if (e_rl[c]) mode[c] = M_IDLE;
                else if (e_pr[c]) begin mode[c] = M_WAIT; t_press[c] = now; end
                else if (mode[c] == M_WAIT) begin
                    if (now - t_press[c] == LONG) begin
                        e_lg[c] = 1'b1; t_phase[c] = now;
                        mode[c] = repeat_en[c] ? M_RPT : M_HOLD;
                    end
                end else if (mode[c] == M_RPT) begin
                    if (!repeat_en[c]) mode[c] = M_HOLD;
                    else if ((now - t_phase[c]) % REP == 0) e_rp[c] = 1'b1;
                end else if (mode[c] == M_HOLD) begin
                    if (repeat_en[c]) begin mode[c] = M_RPT; t_phase[c] = now; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            logic [N_CH-1:0] m;
            m = rst_a_n ? '1 : '0;
            chk("level_out",     int'(level_out),     int'(e_lvl & m));
            chk("press_pulse",   int'(press_pulse),   int'(e_pr & m));
            chk("release_pulse", int'(release_pulse), int'(e_rl & m));
            chk("long_pulse",    int'(long_pulse),    int'(e_lg & m));
            chk("repeat_pulse",  int'(repeat_pulse),  int'(e_rp & m));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int cnt;
    int hl[N_CH];

    initial begin
        rst_a_n = 1'b0; btn_in = '0; repeat_en = '0;
        step(3);
        chk("rst_level",   int'(level_out),     0);
        chk("rst_press",   int'(press_pulse),   0);
        chk("rst_release", int'(release_pulse), 0);
        chk("rst_long",    int'(long_pulse),    0);
        chk("rst_repeat",  int'(repeat_pulse),  0);
        rst_a_n = 1'b1;
        step(2);

        // clean press on ch0: level and press pulse six cycles later
        btn_in[0] = 1'b1;
        step(5); chk("ch0_level_early", int'(level_out[0]), 0);
        step(1); chk("ch0_level", int'(level_out[0]), 1);
        chk("ch0_press", int'(press_pulse[0]), 1);
        step(1); chk("ch0_press_once", int'(press_pulse[0]), 0);

        // bounce on ch1, ending high on the last toggle
        cnt = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k % 2 == 0) btn_in[1] = ~btn_in[1];
            step(1); cnt += int'(press_pulse[1]);
        end
        for (int k = 0; k < 4; k++) begin step(1); cnt += int'(press_pulse[1]); end
        chk("ch1_bounce_quiet", cnt, 0);
        step(1); chk("ch1_press", int'(press_pulse[1]), 1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin step(1); cnt += int'(press_pulse[1]); end
        chk("ch1_single_press", cnt, 0);

        btn_in[1:0] = 2'b00;
        step(12);

        // long press with auto-repeat on ch2
        repeat_en[2] = 1'b1; btn_in[2] = 1'b1;
        step(6);  chk("ch2_press", int'(press_pulse[2]), 1);
        step(19); chk("ch2_long_early", int'(long_pulse[2]), 0);
        step(1);  chk("ch2_long", int'(long_pulse[2]), 1);
        for (int r = 0; r < 3; r++) begin
            step(4); chk("ch2_rep_gap", int'(repeat_pulse[2]), 0);
            step(1); chk("ch2_rep", int'(repeat_pulse[2]), 1);
        end
        btn_in[2] = 1'b0;
        step(5); chk("ch2_rep_before_rel", int'(repeat_pulse[2]), 1);
        step(1); chk("ch2_release", int'(release_pulse[2]), 1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1); cnt += int'(repeat_pulse[2]) + int'(release_pulse[2]);
        end
        chk("ch2_quiet_after_rel", cnt, 0);
        repeat_en[2] = 1'b0;

        // release lands on the long-press threshold
        btn_in[0] = 1'b1;
        step(6);  chk("ch0_press2", int'(press_pulse[0]), 1);
        step(14); btn_in[0] = 1'b0;
        step(6);  chk("ch0_rel_at_long", int'(release_pulse[0]), 1);
        chk("ch0_no_long", int'(long_pulse[0]), 0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin step(1); cnt += int'(long_pulse[0]); end
        chk("ch0_no_long_later", cnt, 0);

        // all channels pressed together
        step(4);
        btn_in = '1;
        step(6); chk("all_press", int'(press_pulse), 15);

        // reset while ch3 is repeating
        repeat_en[3] = 1'b1;
        step(22);
        rst_a_n = 1'b0;
        #1;
        chk("rst_mid_level",   int'(level_out),     0);
        chk("rst_mid_release", int'(release_pulse), 0);
        chk("rst_mid_repeat",  int'(repeat_pulse),  0);
        step(3);
        rst_a_n = 1'b1;
        step(5); chk("post_rst_early", int'(press_pulse), 0);
        step(1); chk("post_rst_press", int'(press_pulse), 15);

        // randomized phase
        btn_in = '0; repeat_en = '0;
        step(12);
        for (int c = 0; c < N_CH; c++) hl[c] = $urandom_range(0, 10);
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hl[c] == 0) begin
                    btn_in[c] = ~btn_in[c];
                    hl[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                        : $urandom_range(4, 60);
                end else begin
                    hl[c]--;
                end
                if ($urandom_range(0, 31) == 0) repeat_en[c] = ~repeat_en[c];
            end
            if (k == 1500) begin
                rst_a_n = 1'b0;
                step(2);
                rst_a_n = 1'b1;
            end
            step(1);
        end

        step(2);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
